// File: rtl/tristate_bus_receiver_if.sv
// ----------------------------------------------------------------------------
// tristate_bus_receiver_if
//   Bundles the shared-line input and the local-side delivery handshake of
//   tristate_bus_receiver.
//
//   Signals:
//     bus_in     shared tristate line (pull-up idle level 1), async to clk
//     rx_ready   consumer accepts rx_data this cycle
//     rx_data    received payload, stable while rx_valid=1
//     rx_valid   holding register full
//     busy       receiver FSM not idle
//     frame_err  one-cycle pulse: stop bit sampled 0
//     overrun    one-cycle pulse: completed frame dropped, holding reg full
//     parity_err one-cycle pulse: parity mismatch (TRISTATE_BUS_RX_PARITY_EN)
//
//   Modports: slave = receiver side, master = line driver / consumer side.
//   Optional macro: TRISTATE_BUS_RX_PARITY_EN adds parity_err.
// ----------------------------------------------------------------------------
interface tristate_bus_receiver_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  bus_in;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  busy;
    logic                  frame_err;
    logic                  overrun;
`ifdef TRISTATE_BUS_RX_PARITY_EN
    logic                  parity_err;
`endif

    modport slave (
        input  bus_in,
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output busy,
        output frame_err,
        output overrun
`ifdef TRISTATE_BUS_RX_PARITY_EN
        , output parity_err
`endif
    );

    modport master (
        output bus_in,
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  busy,
        input  frame_err,
        input  overrun
`ifdef TRISTATE_BUS_RX_PARITY_EN
        , input parity_err
`endif
    );
endinterface

// File: rtl/tristate_bus_receiver.sv
// ----------------------------------------------------------------------------
// tristate_bus_receiver
//   Receive endpoint for a single-wire shared line (idle high via pull-up).
//   Synchronizes the line, detects a start bit, deserializes DATA_WIDTH bits
//   LSB first, checks the stop bit and hands each word over through a
//   one-deep valid/ready holding register.
//
//   Ports:
//     clk          receiver clock
//     rst_n        asynchronous active-low reset
//     bus          tristate_bus_receiver_if.slave (line, handshake, status)
//     o_dbg_state  current FSM state encoding, for observation only
//
//   Handshake: a word transfers on every cycle where rx_valid & rx_ready are
//   both 1 at the rising clk edge; rx_data is held stable while rx_valid=1 and
//   rx_valid never drops without a transfer.
//
//   Optional macro: TRISTATE_BUS_RX_PARITY_EN adds an even-parity bit between
//   the data bits and the stop bit, and the parity_err pulse output.
// ----------------------------------------------------------------------------
module tristate_bus_receiver #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    tristate_bus_receiver_if.slave     bus,
    output logic [2:0]                 o_dbg_state
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_MID     = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    // Loading this at the start-bit midpoint puts the next CNT_MID exactly
    // one bit period later, i.e. in the middle of data bit 0.
    localparam logic [CNT_W-1:0] CNT_REALIGN = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
`ifdef TRISTATE_BUS_RX_PARITY_EN
        , S_PARITY  = 3'd5
`endif
    } state_t;

    state_t                  r_state;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_word_done;
    logic                    r_frame_err;
    logic [DATA_WIDTH-1:0]   r_rx_data;
    logic                    r_rx_valid;
    logic                    r_overrun;
`ifdef TRISTATE_BUS_RX_PARITY_EN
    logic                    r_parity_bit;
    logic                    r_parity_err;
`endif

    logic w_line_s;
    logic w_mid;

    assign w_line_s = r_sync[SYNC_STAGES-1];
    assign w_mid    = (r_cnt == CNT_MID);

    // Synchronizer resets to the idle level so reset release is never seen
    // as a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.bus_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_word_done <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef TRISTATE_BUS_RX_PARITY_EN
            r_parity_bit <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_word_done <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef TRISTATE_BUS_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (!w_line_s) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_mid) begin
                        if (w_line_s) begin
                            r_state <= S_IDLE;       // glitch, not a start bit
                        end else begin
                            r_state <= S_DATA;
                            r_cnt   <= CNT_REALIGN;
                        end
                    end
                end
                S_DATA: begin
                    if (w_mid) begin
                        r_shift[r_idx] <= w_line_s;
                        if (r_idx == IDX_LAST) begin
`ifdef TRISTATE_BUS_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
`ifdef TRISTATE_BUS_RX_PARITY_EN
                S_PARITY: begin
                    if (w_mid) begin
                        r_parity_bit <= w_line_s;
                        r_state      <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_mid) begin
                        if (w_line_s) begin
                            r_state <= S_IDLE;
`ifdef TRISTATE_BUS_RX_PARITY_EN
                            if (^{r_shift, r_parity_bit}) begin
                                r_parity_err <= 1'b1;
                            end else begin
                                r_word_done <= 1'b1;
                            end
`else
                            r_word_done <= 1'b1;
`endif
                        end else begin
                            // Framing error wins over parity; word discarded.
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_HIGH;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    // A line held low (break/contention) must return high
                    // before a new start bit is accepted.
                    if (w_line_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Holding register: a finished word loads if the register is empty or
    // being drained this same cycle; otherwise it is dropped with overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_word_done) begin
                if (!r_rx_valid || bus.rx_ready) begin
                    r_rx_data  <= r_shift;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
`ifdef TRISTATE_BUS_RX_PARITY_EN
    assign bus.parity_err = r_parity_err;
`endif
    assign o_dbg_state   = r_state;

endmodule
